rle_encoder_param: RTL

RLE_ENCODER_PARAM -- requirements
Module: rle_encoder_param

---
 rtl/rle_pkg.sv | 15 +
 rtl/rle_out_stage.sv | 63 ++++++
 rtl/rle_encoder_param.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder: FSM state encoding and
// default symbol/count widths.
package rle_pkg;

    localparam int RLE_DATA_W = 8;
    localparam int RLE_CNT_W  = 8;

    // IDLE: no run held, RUN: a run is being counted, FLUSH: a run waits for the output slot
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rle_state_e;

endpackage

// File: rtl/rle_out_stage.sv
// One-entry valid/ready output register: loads a new pair, holds it while
// the consumer stalls, and replaces it in the same cycle it is consumed.
module rle_out_stage #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] sym_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              free_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] sym_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] sym_q, sym_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    // The slot can take a new pair if it is empty or being drained this cycle.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            sym_d   = sym_i;
            cnt_d   = cnt_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign sym_o   = sym_q;
    assign cnt_o   = cnt_q;
    assign last_o  = last_q;

endmodule

// File: rtl/rle_encoder_param.sv
// Streaming run-length encoder: turns a symbol stream into (symbol, count)
// pairs, splitting runs that reach the maximum count.
module rle_encoder_param
    import rle_pkg::*;
#(
    parameter int DATA_W = RLE_DATA_W,
    parameter int CNT_W  = RLE_CNT_W
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sym,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] MAX_RUN = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    rle_state_e        state_q, state_d;
    logic [DATA_W-1:0] cur_sym_q, cur_sym_d;
    logic [CNT_W-1:0]  cur_cnt_q, cur_cnt_d;

    logic              slot_free;
    logic              accept;
    logic              emit;
    logic [DATA_W-1:0] emit_sym;
    logic [CNT_W-1:0]  emit_cnt;
    logic              emit_last;

    assign in_ready = reset && (state_q != FLUSH) && slot_free;
    assign accept   = in_valid && in_ready;

    // Every emission from IDLE/RUN rides on an accepted beat, which already
    // implies the slot is free, so only FLUSH has to test slot_free itself.
    always_comb begin
        state_d   = state_q;
        cur_sym_d = cur_sym_q;
        cur_cnt_d = cur_cnt_q;
        emit      = 1'b0;
        emit_sym  = cur_sym_q;
        emit_cnt  = cur_cnt_q;
        emit_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_sym_d = in_data;
                    cur_cnt_d = ONE;
                    if (in_last) begin
                        emit      = 1'b1;
                        emit_sym  = in_data;
                        emit_cnt  = ONE;
                        emit_last = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (in_data == cur_sym_q) begin
                        if (cur_cnt_q != MAX_RUN) begin
                            cur_cnt_d = cur_cnt_q + ONE;
                            if (in_last) begin
                                emit      = 1'b1;
                                emit_cnt  = cur_cnt_q + ONE;
                                emit_last = 1'b1;
                                state_d   = IDLE;
                            end
                        end else begin
                            // Saturated: ship the full run and restart counting.
                            emit      = 1'b1;
                            emit_cnt  = MAX_RUN;
                            cur_cnt_d = ONE;
                            if (in_last) begin
                                state_d = FLUSH;
                            end
                        end
                    end else begin
                        emit      = 1'b1;
                        cur_sym_d = in_data;
                        cur_cnt_d = ONE;
                        if (in_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    emit_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cur_sym_q <= '0;
            cur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sym_q <= cur_sym_d;
            cur_cnt_q <= cur_cnt_d;
        end
    end

    rle_out_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_out_stage (
        .clk_i   (fast_clk),
        .rst_ni  (reset),
        .load_i  (emit),
        .sym_i   (emit_sym),
        .cnt_i   (emit_cnt),
        .last_i  (emit_last),
        .ready_i (out_ready),
        .free_o  (slot_free),
        .valid_o (out_valid),
        .sym_o   (out_sym),
        .cnt_o   (out_cnt),
        .last_o  (out_last)
    );

endmodule
